ram_p: RTL and testbench

//   Parameterised single-port synchronous RAM: one shared address bus, one write port, one read port.

---
 rtl/ram_p_pkg.sv | 7 +
 rtl/ram_p.sv | 33 +++
 tb/tb_ram_p.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ram_p_pkg.sv
// rtl/ram_p_pkg.sv - default geometry for the ram_p storage block
package ram_p_pkg;

  localparam int RAM_P_ADDR_WIDTH = 8;
  localparam int RAM_P_DATA_WIDTH = 16;

endpackage

// File: rtl/ram_p.sv
// rtl/ram_p.sv - single-port synchronous RAM, write-first, registered read data
module ram_p
  import ram_p_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_P_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_P_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Reset only clears the output register; the array is never cleared so the
  // block still maps onto a block RAM with a registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
    end else if (write_enable) begin
      mem[address] <= data_in;
      data_out     <= data_in;
    end else begin
      data_out <= mem[address];
    end
  end

endmodule

// File: tb/tb_ram_p.sv
// tb/tb_ram_p.sv - randomized scoreboard bench for ram_p
module tb_ram_p;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [7:0]  address;
  logic [15:0] data_in;
  logic [15:0] data_out;

  ram_p dut (
    .clock        (clock),
    .reset        (reset),
    .write_enable (write_enable),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out)
  );

  initial clock = 1'b0;
  always #2 clock = ~clock;

  typedef struct {
    logic [15:0] exp;
    bit          chk;
    string       name;
  } sb_item_t;

  sb_item_t    sb [$];
  logic [15:0] model_mem [0:255];
  bit          model_known [0:255];
  int          compared   = 0;
  int          mismatched = 0;

  // Reference: reset gives 0, a write returns the new word, otherwise the stored word.
  task automatic step(input logic rst, input logic we, input logic [7:0] a,
                      input logic [15:0] d, input string name);
    sb_item_t it;
    @(negedge clock);
    reset        = rst;
    write_enable = we;
    address      = a;
    data_in      = d;
    it.name = name;
    if (rst) begin
      it.exp = 16'h0000;
      it.chk = 1'b1;
    end else if (we) begin
      model_mem[a]   = d;
      model_known[a] = 1'b1;
      it.exp = d;
      it.chk = 1'b1;
    end else begin
      it.exp = model_mem[a];
      it.chk = model_known[a];
    end
    sb.push_back(it);
  endtask

  initial begin : monitor
    sb_item_t it;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        if (it.chk) begin
          compared++;
          if (data_out !== it.exp) begin
            mismatched++;
            $display("FAIL %s: data_out=%h expected=%h", it.name, data_out, it.exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0]  a;
    logic [15:0] d;
    logic [7:0]  ra [3];
    for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
    reset = 1'b1; write_enable = 1'b0; address = '0; data_in = '0;

    step(1'b1, 1'b1, 8'h30, 16'hDEAD, "reset_0");
    step(1'b1, 1'b1, 8'h31, 16'hBEAD, "reset_1");

    for (int i = 0; i < 256; i++) begin
      d = 16'(i << 8);
      step(1'b0, 1'b1, 8'(i), d, "fill_write");
    end
    for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 8'(i), 16'(~i), "fill_read");
    for (int i = 0; i < 64; i++) begin
      a = 8'($urandom_range(0, 255));
      step(1'b0, 1'b0, a, 16'($urandom), "rand_read");
    end

    step(1'b0, 1'b1, 8'h10, 16'hBEEF, "latency_write");
    step(1'b0, 1'b0, 8'h00, 16'h0000, "latency_addr00");
    step(1'b0, 1'b0, 8'h10, 16'h0000, "latency_addr10");

    step(1'b0, 1'b1, 8'h20, 16'h1111, "rdw_first");
    step(1'b0, 1'b0, 8'h20, 16'h0000, "rdw_read_old");
    step(1'b0, 1'b1, 8'h20, 16'h2222, "rdw_new");

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h20, 16'($urandom), "hold_20");
      step(1'b0, 1'b0, 8'($urandom_range(0, 255)), 16'($urandom), "hold_rand");
    end

    for (int i = 0; i < 3; i++) begin
      ra[i] = 8'($urandom_range(0, 255));
      step(1'b1, 1'b1, ra[i], 16'($urandom), "midreset");
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ra[i], 16'h0000, "after_reset");
    step(1'b0, 1'b0, 8'hFF, 16'h0000, "after_reset_ff");

    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom);
      if ($urandom_range(0, 19) == 0)
        step(1'b1, 1'($urandom), a, d, "rand_reset");
      else
        step(1'b0, 1'($urandom), a, d, "rand_mix");
    end

    repeat (3) @(posedge clock);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
